edf_deadline_tagger: RTL
========================

EDF_DEADLINE_TAGGER -- requirements
Module: edf_deadline_tagger

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the tagged word presented to the priority buffer.
REQ-002 Parameter LABEL_WIDTH, default 8: width of the deadline label and of the timestamp counter.
REQ-003 Parameter FLOW_WIDTH, default 2: flow index width; the deadline table holds 2**FLOW_WIDTH entries.
REQ-004 Parameter GAP_CYCLES, default 4, legal range 2..15: number of cycles from the start of one write pulse to the earliest next accept.
REQ-005 Parameter DEFAULT_DEADLINE, default 16: reset value of every deadline table entry.
REQ-006 clk  in  1  single clock; all state on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 in_valid  in  1  upstream offers a payload.
REQ-009 in_ready  out  1  tagger accepts; the handshake completes when in_valid and in_ready are both 1 at a rising edge.
REQ-010 in_flow  in  FLOW_WIDTH  flow index of the offered payload.
REQ-011 in_payload  in  DATA_WIDTH-LABEL_WIDTH  payload bits.
REQ-012 cfg_we  in  1  deadline table write strobe.
REQ-013 cfg_flow  in  FLOW_WIDTH  table entry to write.
REQ-014 cfg_deadline  in  LABEL_WIDTH  relative deadline in cycles.
REQ-015 full  in  1  downstream priority buffer full.
REQ-016 we  out  1  one-cycle write pulse to the downstream priority buffer.
REQ-017 din  out  DATA_WIDTH  {label, payload}, with the label in the top LABEL_WIDTH bits.
REQ-018 cnt_accepted  out  16  accepted-packet count (see REQ-033).
REQ-019 cnt_stalled  out  16  count of cycles in which in_valid=1 and in_ready=0 (see REQ-033).

Function
REQ-020 now is a free-running LABEL_WIDTH counter that increments every cycle and wraps from all-ones to 0.
REQ-021 The state machine has three states: IDLE, ISSUE and GAP.
REQ-022 in_ready shall be 1 only when the state is IDLE and full is 0; it is a combinational output.
REQ-023 On acceptance in IDLE, the block captures in_payload and computes label = (now + table[in_flow]) mod 2**LABEL_WIDTH, using the now value at the accepting edge, then moves to ISSUE.
REQ-024 In ISSUE, we shall be 1 for exactly one cycle, with din = {label, captured payload}; the next state is GAP.
REQ-025 In GAP, a down-counter holds the block for GAP_CYCLES-1 cycles, then the state returns to IDLE.
REQ-026 The minimum interval between successive we pulses is GAP_CYCLES+1 cycles.
REQ-027 din holds its last value while we is 0.
REQ-028 full is sampled only at acceptance; a write already captured is issued even if full rises during ISSUE.
REQ-029 cfg_we writes table[cfg_flow] <= cfg_deadline.
REQ-030 If cfg_we and an acceptance occur at the same edge on the same flow, the label uses the old table value.
REQ-031 Label arithmetic wraps silently; no overflow flag is produced.

Reset
REQ-032 When rst=0, asynchronously: state=IDLE, we=0, din=0, now=0, gap counter=0, all table entries=DEFAULT_DEADLINE, counters=0.
REQ-032a A packet captured but not yet issued is discarded by reset.
REQ-032b in_ready is 0 while rst=0.

Configuration
REQ-033 With macro EDF_TAGGER_STATS_EN defined, cnt_accepted increments on every acceptance and cnt_stalled increments per stalled cycle; both saturate at 16'hFFFF.
REQ-033a Without EDF_TAGGER_STATS_EN, both counters are constant 0 and no counter registers are built.

Verification
REQ-034 Reset release, table default 16, flow 1 accepted when now=5 -> one we pulse on the next cycle, din[15:8]=8'd21, din[7:0]=payload.
REQ-035 in_valid held high continuously with GAP_CYCLES=4 -> we pulses every 5 cycles and in_ready is high only 1 cycle in 5.
REQ-036 now=250, deadline=10 -> label 8'd4 (wrap).
REQ-037 cfg_we for flow 2 (value 3) at the same edge as a flow-2 acceptance -> label uses 16; the next flow-2 packet uses 3.
REQ-038 full=1 in IDLE with in_valid=1 -> in_ready=0 and no we; cnt_stalled increments when EDF_TAGGER_STATS_EN is defined; full drops -> accept on the next edge.
REQ-039 rst pulled low during ISSUE -> we=0 immediately and no pulse is produced after release; table entries return to 16.

Source files
------------

// File: rtl/edf_deadline_tagger.sv
// EDF deadline tagger: labels each accepted payload with now + per-flow deadline
// and issues it as a single spaced write pulse. Optional stats: EDF_TAGGER_STATS_EN.
module edf_deadline_tagger #(
    parameter int DATA_WIDTH       = 16,
    parameter int LABEL_WIDTH      = 8,
    parameter int FLOW_WIDTH       = 2,
    parameter int GAP_CYCLES       = 4,
    parameter int DEFAULT_DEADLINE = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [FLOW_WIDTH-1:0]             in_flow,
    input  logic [DATA_WIDTH-LABEL_WIDTH-1:0] in_payload,
    input  logic                              cfg_we,
    input  logic [FLOW_WIDTH-1:0]             cfg_flow,
    input  logic [LABEL_WIDTH-1:0]            cfg_deadline,
    input  logic                              full,
    output logic                              we,
    output logic [DATA_WIDTH-1:0]             din,
    output logic [15:0]                       cnt_accepted,
    output logic [15:0]                       cnt_stalled
);

    localparam int DEPTH = 1 << FLOW_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             gap_cnt;
    logic [LABEL_WIDTH-1:0] now;
    logic [LABEL_WIDTH-1:0] deadline_tbl [DEPTH];
    logic [LABEL_WIDTH-1:0] label;
    logic                   accept;

    // Gated by rst so the upstream never sees a handshake while reset is held.
    assign in_ready = rst && (state == IDLE) && !full;
    assign accept   = in_valid && in_ready;
    assign we       = (state == ISSUE);
    assign label    = now + deadline_tbl[in_flow];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = GAP;
            GAP:     if (gap_cnt <= 4'd1) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            now <= '0;
        end else begin
            now <= now + 1'b1;
        end
    end

    // GAP lasts GAP_CYCLES-1 cycles, so pulses are GAP_CYCLES+1 cycles apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if (state == ISSUE) begin
            gap_cnt <= 4'(GAP_CYCLES - 1);
        end else if (state == GAP && gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // din is loaded at acceptance and only changes on the next acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din <= '0;
        end else if (accept) begin
            din <= {label, in_payload};
        end
    end

    // NOTE: the table is a handful of registers that must come up at a known
    // deadline, so every entry is reset (unlike a RAM-style memory).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                deadline_tbl[i] <= LABEL_WIDTH'(DEFAULT_DEADLINE);
            end
        end else if (cfg_we) begin
            deadline_tbl[cfg_flow] <= cfg_deadline;
        end
    end

`ifdef EDF_TAGGER_STATS_EN
    logic [15:0] acc_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (accept && acc_q != 16'hFFFF) begin
                acc_q <= acc_q + 1'b1;
            end
            if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign cnt_accepted = acc_q;
    assign cnt_stalled  = stall_q;
`else
    assign cnt_accepted = '0;
    assign cnt_stalled  = '0;
`endif

endmodule
